if3_multi_redirect: RTL

- Third fetch-stage predecode and redirect unit, generalised from the fixed 2-wide stage to FETCH_WIDTH lanes.
- Sits between the IF2/IF3 pipeline registers and the IF3/decode registers.
- Predecodes MIPS control instructions per lane, merges BPD and NLP predictions, and raises one redirect/flush per cycle when the final prediction disagrees with the NLP.
- A delay-slot FSM carries a redirect across packets when the mispredicted control instruction sits in the last lane.

---
 rtl/if3_multi_redirect_if.sv | 40 ++++
 rtl/if3_multi_redirect.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/if3_multi_redirect_if.sv
// IF3 predecode/redirect bus: IF2/IF3 lane inputs, predictor inputs, and decode/redirect outputs.
interface if3_multi_redirect_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int PC_W        = 32
);
  logic [FETCH_WIDTH-1:0]      in_valid;
  logic [FETCH_WIDTH*PC_W-1:0] in_pc;
  logic [FETCH_WIDTH*32-1:0]   in_inst;
  logic [FETCH_WIDTH-1:0]      nlp_valid;
  logic [FETCH_WIDTH-1:0]      nlp_taken;
  logic [FETCH_WIDTH*PC_W-1:0] nlp_target;
  logic                        pred_valid;
  logic                        pred_taken;
  logic [PC_W-1:0]             pred_target;

  logic [FETCH_WIDTH-1:0]      out_valid;
  logic [FETCH_WIDTH-1:0]      out_is_j;
  logic [FETCH_WIDTH-1:0]      out_is_br;
  logic [FETCH_WIDTH-1:0]      out_pred_taken;
  logic [FETCH_WIDTH*PC_W-1:0] out_pred_addr;
  logic [FETCH_WIDTH-1:0]      out_jbad;
  logic                        redirect;
  logic [PC_W-1:0]             redirect_pc;
  logic                        flush_req;
  logic                        is_branch;

  modport master (
    output in_valid, in_pc, in_inst, nlp_valid, nlp_taken, nlp_target,
           pred_valid, pred_taken, pred_target,
    input  out_valid, out_is_j, out_is_br, out_pred_taken, out_pred_addr,
           out_jbad, redirect, redirect_pc, flush_req, is_branch
  );

  modport slave (
    input  in_valid, in_pc, in_inst, nlp_valid, nlp_taken, nlp_target,
           pred_valid, pred_taken, pred_target,
    output out_valid, out_is_j, out_is_br, out_pred_taken, out_pred_addr,
           out_jbad, redirect, redirect_pc, flush_req, is_branch
  );
endinterface

// File: rtl/if3_multi_redirect.sv
// IF3 predecode + BPD/NLP merge: all outputs combinational, one redirect per cycle, pause suppresses redirects.
// Registers are only the delay-slot state and saved_pc; IF3_REDIRECT_STATS_EN adds redirect/delay-slot counters.
module if3_multi_redirect #(
  parameter int FETCH_WIDTH = 4,
  parameter int PC_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                pause,
  if3_multi_redirect_if.slave bus
`ifdef IF3_REDIRECT_STATS_EN
  ,
  output logic [31:0]         stat_redirects,
  output logic [31:0]         stat_ds_waits
`endif
);
  localparam int W = FETCH_WIDTH;

  typedef enum logic {IDLE = 1'b0, WAIT_DS = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] saved_pc, saved_nxt;

  logic [W-1:0]    is_dj, is_jr, is_br, is_ctrl, first_ctrl, pred_tk, mis;
  logic [PC_W-1:0] lane_pc   [W];
  logic [PC_W-1:0] dec_tgt   [W];
  logic [PC_W-1:0] pred_addr [W];
  logic [PC_W-1:0] fix_tgt   [W];

  logic            seen;
  logic            mis_hit, m_last;
  logic [PC_W-1:0] corr_tgt;
  logic [W-1:0]    keep, vmask;
  logic            redir;
  logic [PC_W-1:0] rpc;

  for (genvar g = 0; g < W; g++) begin : g_lane
    logic [5:0]      op, funct;
    logic [4:0]      rt;
    logic [25:0]     idx;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc4, nlp_tgt, ad;
    logic            nlp_tk, use_bpd, tk;

    assign op      = bus.in_inst[g*32+26 +: 6];
    assign rt      = bus.in_inst[g*32+16 +: 5];
    assign funct   = bus.in_inst[g*32 +: 6];
    assign idx     = bus.in_inst[g*32 +: 26];
    assign imm     = bus.in_inst[g*32 +: 16];
    assign lane_pc[g] = bus.in_pc[g*PC_W +: PC_W];
    assign pc4     = lane_pc[g] + PC_W'(4);
    assign nlp_tgt = bus.nlp_target[g*PC_W +: PC_W];
    assign nlp_tk  = bus.nlp_valid[g] & bus.nlp_taken[g];

    assign is_dj[g] = bus.in_valid[g] && (op == 6'b000010 || op == 6'b000011);
    assign is_jr[g] = bus.in_valid[g] && op == 6'b000000 &&
                      (funct == 6'b001000 || funct == 6'b001001);
    assign is_br[g] = bus.in_valid[g] &&
                      ((op >= 6'b000100 && op <= 6'b000111) ||
                       (op == 6'b000001 && (rt == 5'b00000 || rt == 5'b00001 ||
                                            rt == 5'b10000 || rt == 5'b10001)));
    assign is_ctrl[g] = is_dj[g] | is_jr[g] | is_br[g];

    assign dec_tgt[g] = is_dj[g] ? {pc4[PC_W-1:28], idx, 2'b00}
                                 : pc4 + {{(PC_W-18){imm[15]}}, imm, 2'b00};

    // Only the oldest control instruction in the packet owns the BPD prediction.
    assign use_bpd = first_ctrl[g] & bus.pred_valid;

    always_comb begin
      tk = 1'b0;
      ad = '0;
      if (is_dj[g]) begin
        tk = 1'b1;
        ad = dec_tgt[g];
      end else if (is_jr[g]) begin
        if (use_bpd) begin
          tk = 1'b1;
          ad = bus.pred_target;
        end else if (bus.nlp_valid[g]) begin
          tk = 1'b1;
          ad = nlp_tgt;
        end
      end else if (is_br[g]) begin
        ad = dec_tgt[g];
        if (use_bpd) begin
          tk = bus.pred_taken;
        end else if (bus.nlp_valid[g]) begin
          tk = bus.nlp_taken[g];
        end
      end
    end

    assign pred_tk[g]   = tk;
    assign pred_addr[g] = ad;
    assign mis[g]       = bus.in_valid[g] &&
                          ((tk != nlp_tk) || (tk && nlp_tk && ad != nlp_tgt));
    assign fix_tgt[g]   = tk ? ad : lane_pc[g] + PC_W'(8);

    assign bus.out_pred_addr[g*PC_W +: PC_W] = ad;
    assign bus.out_jbad[g] = is_dj[g] && (dec_tgt[g][1:0] != 2'b00);
  end

  always_comb begin
    first_ctrl = '0;
    seen       = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (is_ctrl[i] && !seen) begin
        first_ctrl[i] = 1'b1;
        seen          = 1'b1;
      end
    end
  end

  // Lowest mismatching lane wins; its delay slot (m+1) survives, younger lanes are killed.
  always_comb begin
    mis_hit  = 1'b0;
    m_last   = 1'b0;
    corr_tgt = '0;
    keep     = '1;
    for (int i = 0; i < W; i++) begin
      if (mis[i] && !mis_hit) begin
        mis_hit  = 1'b1;
        m_last   = (i == W - 1);
        corr_tgt = fix_tgt[i];
        for (int j = 0; j < W; j++) begin
          if (j > i + 1) keep[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      saved_pc <= '0;
    end else begin
      state    <= state_nxt;
      saved_pc <= saved_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    saved_nxt = saved_pc;
    redir     = 1'b0;
    rpc       = '0;
    if (rst || flush) begin
      state_nxt = IDLE;
      saved_nxt = '0;
    end else if (!pause) begin
      case (state)
        IDLE: begin
          if (mis_hit) begin
            if (m_last) begin
              // Delay slot lives in the next packet; redirect once it arrives.
              saved_nxt = corr_tgt;
              state_nxt = WAIT_DS;
            end else begin
              redir = 1'b1;
              rpc   = corr_tgt;
            end
          end
        end
        WAIT_DS: begin
          if (bus.in_valid[0]) begin
            redir     = 1'b1;
            rpc       = saved_pc;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    vmask = '1;
    if (state == WAIT_DS) vmask = W'(1);
    else if (redir)       vmask = keep;
  end

  assign bus.out_valid      = bus.in_valid & vmask;
  assign bus.out_is_j       = is_dj | is_jr;
  assign bus.out_is_br      = is_br;
  assign bus.out_pred_taken = pred_tk;
  assign bus.redirect       = redir;
  assign bus.redirect_pc    = rpc;
  assign bus.flush_req      = redir;
  assign bus.is_branch      = |is_ctrl;

`ifdef IF3_REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_redirects <= '0;
      stat_ds_waits  <= '0;
    end else begin
      if (redir) stat_redirects <= stat_redirects + 32'd1;
      if (state == IDLE && state_nxt == WAIT_DS) stat_ds_waits <= stat_ds_waits + 32'd1;
    end
  end
`endif
endmodule
